// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared constants for the pipelined barrel shifter: operating modes, shift
// directions and the legality rule for the data width.
package pipelined_barrel_shifter_pkg;

    localparam logic [1:0] MODE_LOGICAL  = 2'b00;
    localparam logic [1:0] MODE_ARITH    = 2'b01;
    localparam logic [1:0] MODE_ROTATE   = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Width must be a power of two so the shift amount maps onto mux levels exactly.
    function automatic logic isLegalWidth(input int width);
        return (width >= 4) && ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One mux level of the barrel shifter: shifts by 2**LEVEL when the matching
// shift bit is set, then registers the beat with its control fields.
module barrel_shift_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEVEL = 0,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              upValid,
    input  logic [WIDTH-1:0]  upData,
    input  logic [LEVELS-1:0] upShift,
    input  logic              upDirection,
    input  logic [1:0]        upMode,
    input  logic              upCarry,
    input  logic              succLoad,
    output logic              stageValid,
    output logic [WIDTH-1:0]  stageData,
    output logic [LEVELS-1:0] stageShift,
    output logic              stageDirection,
    output logic [1:0]        stageMode,
    output logic              stageCarry
);

    localparam int STEP = 1 << LEVEL;

    logic              validReg;
    logic [WIDTH-1:0]  dataReg;
    logic [LEVELS-1:0] shiftReg;
    logic              directionReg;
    logic [1:0]        modeReg;
    logic              carryReg;

    logic              load;
    logic [WIDTH-1:0]  dataNext;
    logic              carryNext;
    logic              carryFromShift;
    logic [LEVELS-1:0] idxRight;
    logic [LEVELS-1:0] idxLeft;

    assign load = !validReg || succLoad;

    always_comb begin
        dataNext = upData;
        if (upShift[LEVEL]) begin
            if (upDirection == DIR_LEFT) begin
                if (upMode == MODE_ROTATE) begin
                    dataNext = (upData << STEP) | (upData >> (WIDTH - STEP));
                end else begin
                    dataNext = upData << STEP;
                end
            end else begin
                case (upMode)
                    MODE_ARITH:  dataNext = WIDTH'($signed(upData) >>> STEP);
                    MODE_ROTATE: dataNext = (upData >> STEP) | (upData << (WIDTH - STEP));
                    default:     dataNext = upData >> STEP;
                endcase
            end
        end
    end

    // WIDTH - n wraps to -n modulo WIDTH, so both carry indices fit in LEVELS bits.
    assign idxRight = upShift - LEVELS'(1);
    assign idxLeft  = LEVELS'(0) - upShift;

    always_comb begin
        carryFromShift = 1'b0;
        if (upShift != '0) begin
            carryFromShift = (upDirection == DIR_LEFT) ? upData[idxLeft] : upData[idxRight];
        end
        carryNext = (LEVEL == 0) ? carryFromShift : upCarry;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            validReg     <= 1'b0;
            dataReg      <= '0;
            shiftReg     <= '0;
            directionReg <= 1'b0;
            modeReg      <= '0;
            carryReg     <= 1'b0;
        end else if (load) begin
            validReg <= upValid;
            // Payload only moves with a real beat so a drained stage keeps its last result.
            if (upValid) begin
                dataReg      <= dataNext;
                shiftReg     <= upShift;
                directionReg <= upDirection;
                modeReg      <= upMode;
                carryReg     <= carryNext;
            end
        end
    end

    assign stageValid     = validReg;
    assign stageData      = dataReg;
    assign stageShift     = shiftReg;
    assign stageDirection = directionReg;
    assign stageMode      = modeReg;
    assign stageCarry     = carryReg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Valid/ready barrel shifter with one register stage per shift-amount bit;
// supports logical, arithmetic and rotate shifts in both directions.
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              pipelined_barrel_shifter_port_clk,
    input  logic              pipelined_barrel_shifter_port_rst_n,
    input  logic              pipelined_barrel_shifter_port_in_valid,
    output logic              pipelined_barrel_shifter_port_in_ready,
    input  logic [WIDTH-1:0]  pipelined_barrel_shifter_port_in_data,
    input  logic [LEVELS-1:0] pipelined_barrel_shifter_port_in_shift,
    input  logic              pipelined_barrel_shifter_port_in_direction,
    input  logic [1:0]        pipelined_barrel_shifter_port_in_mode,
    output logic              pipelined_barrel_shifter_port_out_valid,
    input  logic              pipelined_barrel_shifter_port_out_ready,
    output logic [WIDTH-1:0]  pipelined_barrel_shifter_port_out_data,
    output logic              pipelined_barrel_shifter_port_out_carry,
    output logic              pipelined_barrel_shifter_port_out_zero
);

    if (!isLegalWidth(WIDTH)) begin : badWidth
        $error("pipelined_barrel_shifter: WIDTH must be a power of two and at least 4");
    end

    logic [LEVELS-1:0] validVec;
    logic [LEVELS-1:0] directionVec;
    logic [LEVELS-1:0] carryVec;
    logic [WIDTH-1:0]  stageData  [LEVELS];
    logic [LEVELS-1:0] stageShift [LEVELS];
    logic [1:0]        stageMode  [LEVELS];

    logic              srcValid     [LEVELS];
    logic [WIDTH-1:0]  srcData      [LEVELS];
    logic [LEVELS-1:0] srcShift     [LEVELS];
    logic              srcDirection [LEVELS];
    logic [1:0]        srcMode      [LEVELS];
    logic              srcCarry     [LEVELS];
    logic              succLoad     [LEVELS];

    for (genvar gi = 0; gi < LEVELS; gi++) begin : stageGen
        if (gi == 0) begin : fromPort
            assign srcValid[gi]     = pipelined_barrel_shifter_port_in_valid;
            assign srcData[gi]      = pipelined_barrel_shifter_port_in_data;
            assign srcShift[gi]     = pipelined_barrel_shifter_port_in_shift;
            assign srcDirection[gi] = pipelined_barrel_shifter_port_in_direction;
            assign srcMode[gi]      = pipelined_barrel_shifter_port_in_mode;
            assign srcCarry[gi]     = 1'b0;
        end else begin : fromStage
            assign srcValid[gi]     = validVec[gi-1];
            assign srcData[gi]      = stageData[gi-1];
            assign srcShift[gi]     = stageShift[gi-1];
            assign srcDirection[gi] = directionVec[gi-1];
            assign srcMode[gi]      = stageMode[gi-1];
            assign srcCarry[gi]     = carryVec[gi-1];
        end

        // A successor loads when out_ready is high or any stage from it to the end is empty;
        // written in closed form so the ready path stays a flat OR tree.
        if (gi == LEVELS - 1) begin : toPort
            assign succLoad[gi] = pipelined_barrel_shifter_port_out_ready;
        end else begin : toStage
            assign succLoad[gi] = pipelined_barrel_shifter_port_out_ready
                                | ~(&validVec[LEVELS-1:gi+1]);
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .LEVEL (gi)
        ) stageInst (
            .clk            (pipelined_barrel_shifter_port_clk),
            .rstN           (pipelined_barrel_shifter_port_rst_n),
            .upValid        (srcValid[gi]),
            .upData         (srcData[gi]),
            .upShift        (srcShift[gi]),
            .upDirection    (srcDirection[gi]),
            .upMode         (srcMode[gi]),
            .upCarry        (srcCarry[gi]),
            .succLoad       (succLoad[gi]),
            .stageValid     (validVec[gi]),
            .stageData      (stageData[gi]),
            .stageShift     (stageShift[gi]),
            .stageDirection (directionVec[gi]),
            .stageMode      (stageMode[gi]),
            .stageCarry     (carryVec[gi])
        );
    end

    // Control fields of the final stage have no consumer.
    logic unusedTail;
    assign unusedTail = ^{stageShift[LEVELS-1], directionVec[LEVELS-1], stageMode[LEVELS-1]};

    assign pipelined_barrel_shifter_port_in_ready = pipelined_barrel_shifter_port_out_ready
                                                  | ~(&validVec);
    assign pipelined_barrel_shifter_port_out_valid = validVec[LEVELS-1];
    assign pipelined_barrel_shifter_port_out_data  = stageData[LEVELS-1];
    assign pipelined_barrel_shifter_port_out_carry = carryVec[LEVELS-1];
    assign pipelined_barrel_shifter_port_out_zero  = ~(|stageData[LEVELS-1]);

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two, >= 4 (elaboration error otherwise).
REQ-002 Derived constant LEVELS = $clog2(WIDTH): shift-amount width and pipeline depth.
REQ-003 pipelined_barrel_shifter_port_clk  in  1  single clock, all state on rising edge.
REQ-004 pipelined_barrel_shifter_port_rst_n  in  1  synchronous, active-low reset.
REQ-005 pipelined_barrel_shifter_port_in_valid  in  1  input beat present.
REQ-006 pipelined_barrel_shifter_port_in_ready  out  1  block can accept a beat this cycle.
REQ-007 pipelined_barrel_shifter_port_in_data  in  WIDTH  operand.
REQ-008 pipelined_barrel_shifter_port_in_shift  in  LEVELS  shift amount, 0..WIDTH-1.
REQ-009 pipelined_barrel_shifter_port_in_direction  in  1  0 = right, 1 = left.
REQ-010 pipelined_barrel_shifter_port_in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-011 pipelined_barrel_shifter_port_out_valid  out  1  result beat present.
REQ-012 pipelined_barrel_shifter_port_out_ready  in  1  downstream accepts result.
REQ-013 pipelined_barrel_shifter_port_out_data  out  WIDTH  shifted result.
REQ-014 pipelined_barrel_shifter_port_out_carry  out  1  last bit shifted (or rotated) out; 0 when shift = 0.
REQ-015 pipelined_barrel_shifter_port_out_zero  out  1  out_data == 0.

Function
REQ-016 Transfer occurs on a cycle where valid and ready are both high, on either port.
REQ-017 Pipeline SHALL have LEVELS register stages; stage k applies a shift of 2^k when in_shift[k] = 1, else passes through.
REQ-018 Latency: a beat accepted in cycle t SHALL appear on out_data in cycle t+LEVELS when no stall occurs.
REQ-019 Throughput: one beat per cycle sustained while out_ready = 1.
REQ-020 Each stage SHALL carry its own valid bit plus direction, mode, remaining shift bits, and carry.
REQ-021 A stage SHALL load when it is empty or its successor loads (or, for the last stage, out_ready = 1); otherwise it holds.
REQ-022 in_ready SHALL equal the load condition of stage 0; ready may ripple combinationally from out_ready.
REQ-023 While out_valid = 1 and out_ready = 0, out_data, out_carry and out_zero SHALL remain stable.
REQ-024 Logical: vacated bits filled with 0. Arithmetic right: vacated bits filled with in_data[WIDTH-1]. Arithmetic left: identical to logical left.
REQ-025 Rotate: bits leaving one end enter the other; no fill.
REQ-026 Carry SHALL be computed at stage 0 from the full shift amount n: right gives in_data[n-1]; left gives in_data[WIDTH-n]; n = 0 gives 0. Carry is then pipelined alongside the data.
REQ-027 out_zero SHALL be derived combinationally from the final-stage data register.
REQ-028 Beats SHALL emerge in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-029 Full pipeline (all stages valid, out_ready = 0): in_ready = 0. Empty pipeline: in_ready = 1 regardless of out_ready.

Reset
REQ-030 When rst_n = 0 at a rising edge, all stage valid bits, data, carry and control registers SHALL clear to 0.
REQ-031 During and after reset: out_valid = 0, out_data = 0, out_carry = 0, out_zero = 1, in_ready = 1.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; none appears after release.

Structure
REQ-033 Package pipelined_barrel_shifter_pkg SHALL hold the mode constants (MODE_LOGICAL, MODE_ARITH, MODE_ROTATE) and the direction constants (DIR_RIGHT, DIR_LEFT).
REQ-034 One sub-module, barrel_shift_stage (parameters WIDTH, LEVEL), SHALL implement one mux level plus its registers and valid/load logic; the top SHALL instantiate it LEVELS times through a generate loop.

Verification (WIDTH = 8, latency 3)
REQ-035 Logical right: 8'b1011_0010 >> 3 -> out_data 8'b0001_0110, carry 0, zero 0, on cycle t+3.
REQ-036 Arithmetic right: 8'b1011_0010 >> 3 -> 8'b1111_0110, carry 0; rotate left: 8'b1000_0001 by 1 -> 8'b0000_0011, carry 1.
REQ-037 Boundaries: logical left 8'h80 by 1 -> 8'h00, carry 1, zero 1; any mode with shift 0 -> data unchanged, carry 0.
REQ-038 Backpressure: hold out_ready = 0 while driving 5 back-to-back beats -> exactly 3 accepted, then in_ready = 0; releasing out_ready drains results in order, outputs stable while stalled.
REQ-039 Random out_ready/in_valid for 10k beats, checked against a reference model -> every result matches, in order, none dropped.
REQ-040 Reset asserted with 2 beats in flight -> out_valid = 0 on the next cycle; no stale beat appears after release.
